// File: rtl/game_pkg.sv
// Shared definitions for the rhythm-game sequencer and its datapath:
// default timing parameters and the FSM state encodings.
package game_pkg;

  // 8 Hz beat from a 50 MHz clock
  localparam int TICK_DIV_DEFAULT    = 6250000;
  localparam int SONG_LEN_DEFAULT    = 191;
  localparam int COUNT_BEATS_DEFAULT = 8;

  localparam int STATE_W = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_COUNT = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/game_sequencer_if.sv
// Control bundle between the sequencer (master) and the game datapath /
// display logic (slave).
interface game_sequencer_if;
  import game_pkg::*;

  logic               start_n;
  logic               abort;
  logic               load_map;
  logic               shift_en;
  logic               judge_en;
  logic [3:0]         count_left;
  logic [7:0]         beats_left;
  logic               song_done;
  logic [STATE_W-1:0] state;

  modport master (
    input  start_n, abort,
    output load_map, shift_en, judge_en, count_left, beats_left, song_done, state
  );

  modport slave (
    output start_n, abort,
    input  load_map, shift_en, judge_en, count_left, beats_left, song_done, state
  );

endinterface

// File: rtl/key_sync.sv
// Two-flop synchroniser for an active-low push button followed by a
// falling-edge detector; press is high for one clk per button push.
module key_sync (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;

  // Resynchronise the raw key and keep one extra stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = prev & ~sync2;

endmodule

// File: rtl/game_sequencer.sv
// Song sequencer: lead-in count, beat-paced play with pause/resume,
// and replay from the finished state. Drives the datapath via the bus.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int SONG_LEN    = SONG_LEN_DEFAULT,
  parameter int COUNT_BEATS = COUNT_BEATS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  game_sequencer_if.master bus
);

  localparam int              DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [3:0]      COUNT_INIT = 4'(COUNT_BEATS);
  localparam logic [7:0]      SONG_INIT  = 8'(SONG_LEN);

  logic [2:0]       state;
  logic [DIV_W-1:0] div;
  logic [3:0]       count_left;
  logic [7:0]       beats_left;
  logic             press;
  logic             beat;

  key_sync u_start_sync (
    .clk   (clk),
    .rst   (rst),
    .key_n (bus.start_n),
    .press (press)
  );

  assign beat = (div == DIV_LAST);

  // Main FSM with beat divider and saturating lead-in / song counters
  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      state      <= ST_IDLE;
      div        <= '0;
      count_left <= '0;
      beats_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          div        <= '0;
          count_left <= '0;
          beats_left <= '0;
          if (press) state <= ST_LOAD;
        end
        ST_LOAD: begin
          div        <= '0;
          count_left <= COUNT_INIT;
          beats_left <= SONG_INIT;
          state      <= ST_COUNT;
        end
        ST_COUNT: begin
          if (beat) begin
            div <= '0;
            if (count_left <= 4'd1) begin
              count_left <= '0;
              state      <= ST_PLAY;
            end else begin
              count_left <= count_left - 4'd1;
            end
          end else begin
            div <= div + DIV_ONE;
          end
        end
        ST_PLAY: begin
          if (press) begin
            state <= ST_PAUSE;
          end else if (beat) begin
            div <= '0;
            if (beats_left <= 8'd1) begin
              beats_left <= '0;
              state      <= ST_DONE;
            end else begin
              beats_left <= beats_left - 8'd1;
            end
          end else begin
            div <= div + DIV_ONE;
          end
        end
        ST_PAUSE: begin
          if (press) state <= ST_PLAY;
        end
        ST_DONE: begin
          div <= '0;
          if (press) state <= ST_LOAD;
        end
        default: begin
          state      <= ST_IDLE;
          div        <= '0;
          count_left <= '0;
          beats_left <= '0;
        end
      endcase
    end
  end

  assign bus.state      = state;
  assign bus.count_left = count_left;
  assign bus.beats_left = beats_left;
  assign bus.load_map   = (state == ST_LOAD);
  assign bus.judge_en   = (state == ST_PLAY);
  assign bus.song_done  = (state == ST_DONE);
  assign bus.shift_en   = (state == ST_PLAY) & beat & ~press & ~bus.abort & ~rst;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios followed by random button,
// abort and reset activity, checked every cycle against a timeline model.
module tb_game_sequencer;

  localparam int TD   = 4;
  localparam int SL   = 5;
  localparam int CB   = 2;
  localparam int LEAD = TD * CB;

  localparam int S_IDLE  = 0;
  localparam int S_LOAD  = 1;
  localparam int S_COUNT = 2;
  localparam int S_PLAY  = 3;
  localparam int S_PAUSE = 4;
  localparam int S_DONE  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  game_sequencer_if bus ();

  game_sequencer #(
    .TICK_DIV    (TD),
    .SONG_LEN    (SL),
    .COUNT_BEATS (CB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: current mode, cycles of running time since entering the lead-in,
  // and the last three sampled values of the key
  int   m_mode;
  int   m_run;
  logic h0, h1, h2;

  logic obs_load, obs_shift, obs_done;
  int   obs_state, obs_beats;
  logic prev_pulse;

  int   first_load, first_play, first_done, n_load, pulses, guard;
  int   shift_q[$];
  logic sn, ab, rs;

  function automatic logic m_press();
    return h2 & ~h1;
  endfunction

  function automatic int exp_count();
    if (m_mode == S_COUNT) return CB - m_run / TD;
    return 0;
  endfunction

  function automatic int exp_beats();
    if (m_mode == S_COUNT) return SL;
    if (m_mode == S_PLAY || m_mode == S_PAUSE) return SL - (m_run - LEAD) / TD;
    return 0;
  endfunction

  function automatic logic exp_shift();
    return (m_mode == S_PLAY) && (((m_run - LEAD) % TD) == TD - 1) &&
           !m_press() && !bus.abort && !rst;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic p;
    p = m_press();
    if (rst) begin
      m_mode = S_IDLE;
      m_run  = 0;
      h0 = 1'b1;
      h1 = 1'b1;
      h2 = 1'b1;
    end else begin
      if (bus.abort) begin
        m_mode = S_IDLE;
        m_run  = 0;
      end else begin
        case (m_mode)
          S_IDLE:  if (p) m_mode = S_LOAD;
          S_LOAD:  begin m_mode = S_COUNT; m_run = 0; end
          S_COUNT: begin
            m_run++;
            if (m_run == LEAD) m_mode = S_PLAY;
          end
          S_PLAY: begin
            if (p) m_mode = S_PAUSE;
            else begin
              m_run++;
              if (m_run - LEAD == SL * TD) m_mode = S_DONE;
            end
          end
          S_PAUSE: if (p) m_mode = S_PLAY;
          S_DONE:  if (p) m_mode = S_LOAD;
          default: m_mode = S_IDLE;
        endcase
      end
      h2 = h1;
      h1 = h0;
      h0 = bus.start_n;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    obs_load  = bus.load_map;
    obs_shift = bus.shift_en;
    obs_done  = bus.song_done;
    obs_state = int'(bus.state);
    obs_beats = int'(bus.beats_left);
    checkOutput("state",      32'(bus.state),      32'(m_mode));
    checkOutput("count_left", 32'(bus.count_left), 32'(exp_count()));
    checkOutput("beats_left", 32'(bus.beats_left), 32'(exp_beats()));
    checkOutput("load_map",   32'(bus.load_map),   32'(m_mode == S_LOAD));
    checkOutput("shift_en",   32'(bus.shift_en),   32'(exp_shift()));
    checkOutput("judge_en",   32'(bus.judge_en),   32'(m_mode == S_PLAY));
    checkOutput("song_done",  32'(bus.song_done),  32'(m_mode == S_DONE));
    checkOutput("pulse_excl", 32'(bus.load_map & bus.shift_en), 32'd0);
    checkOutput("pulse_consec", 32'((bus.load_map | bus.shift_en) & prev_pulse), 32'd0);
    prev_pulse = bus.load_map | bus.shift_en;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic applyStimulus(input logic start_n, input logic abort, input logic reset);
    bus.start_n = start_n;
    bus.abort   = abort;
    rst         = reset;
    tick();
  endtask

  initial begin
    bus.start_n = 1'b1;
    bus.abort   = 1'b0;
    rst         = 1'b1;
    m_mode      = S_IDLE;
    m_run       = 0;
    h0 = 1'b1;
    h1 = 1'b1;
    h2 = 1'b1;
    prev_pulse  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b1);

    $display("[TB] reset state");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("reset_state", 32'(obs_state), 32'(S_IDLE));
    checkOutput("reset_beats", 32'(obs_beats), 32'd0);

    $display("[TB] start latency and full song");
    first_load = -1; first_play = -1; first_done = -1; n_load = 0;
    shift_q.delete();
    for (int i = 0; i < 40; i++) begin
      applyStimulus((i == 0) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      if (obs_load) begin
        n_load++;
        if (first_load < 0) first_load = i;
      end
      if (obs_state == S_PLAY && first_play < 0) first_play = i;
      if (obs_shift) shift_q.push_back(i);
      if (obs_done && first_done < 0) first_done = i;
    end
    checkOutput("load_cycle",  32'(first_load), 32'd3);
    checkOutput("load_count",  32'(n_load), 32'd1);
    checkOutput("play_cycle",  32'(first_play), 32'd12);
    checkOutput("shift_count", 32'(shift_q.size()), 32'(SL));
    for (int k = 1; k < shift_q.size(); k++)
      checkOutput("shift_gap", 32'(shift_q[k] - shift_q[k-1]), 32'(TD));
    checkOutput("done_cycle",  32'(first_done), 32'd32);

    $display("[TB] replay from done");
    n_load = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i == 0) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      if (obs_load) n_load++;
    end
    checkOutput("replay_load", 32'(n_load), 32'd1);

    $display("[TB] abort with press during lead-in");
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    n_load = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (i == 0) checkOutput("abort_state", 32'(obs_state), 32'(S_IDLE));
      if (obs_load) n_load++;
    end
    checkOutput("abort_no_load", 32'(n_load), 32'd0);

    $display("[TB] pause on a beat and resume");
    applyStimulus(1'b0, 1'b0, 1'b0);
    guard = 0;
    while (!(m_mode == S_PLAY && ((m_run - LEAD) % TD) == 1) && guard < 60) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      guard++;
    end
    checkOutput("reach_play_timeout", 32'(guard < 60), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("press_on_beat_shift", 32'(obs_shift), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        checkOutput("pause_state", 32'(obs_state), 32'(S_PAUSE));
        checkOutput("pause_beats", 32'(obs_beats), 32'(SL));
      end
      if (obs_load || obs_shift) pulses++;
    end
    checkOutput("pause_pulses", 32'(pulses), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_phase", 32'(obs_shift), 32'd1);

    $display("[TB] reset mid-song");
    guard = 0;
    while (!(m_mode == S_PLAY && exp_beats() == 3) && guard < 40) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      guard++;
    end
    checkOutput("reach_beats3_timeout", 32'(guard < 40), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("midsong_reset_state", 32'(obs_state), 32'(S_IDLE));
    checkOutput("midsong_reset_beats", 32'(obs_beats), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (obs_shift) pulses++;
    end
    checkOutput("post_reset_shift", 32'(pulses), 32'd0);

    $display("[TB] random button / abort / reset activity");
    sn = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (sn && $urandom_range(0, 99) < 3) sn = 1'b0;
      else if (!sn && $urandom_range(0, 99) >= 50) sn = 1'b1;
      ab = ($urandom_range(0, 149) == 0);
      rs = ($urandom_range(0, 399) == 0);
      applyStimulus(sn, ab, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
